// File: rtl/pixel_filter_stream.sv
// pixel_filter_stream: 3-stage pipelined RGB filter (gray/pink/pass/invert/threshold) on a valid/ready stream
// Ports: clk, reset_n (async, active-low); in_data/in_valid/in_sop/in_eop/in_ready input stream;
// filter_selection, pitch_output sampled at each accepted SOP; out_data/out_valid/out_sop/out_eop/out_ready
// output stream; active_mode reports the mode latched for the current frame.
module pixel_filter_stream #(
    parameter int IN_BITS   = 4,
    parameter int OUT_BITS  = 10,
    parameter int PITCH_W   = 30,
    parameter int PITCH_MIN = 10,
    parameter int PITCH_MAX = 63,
    parameter int THRESH    = 512
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3*IN_BITS-1:0]  in_data,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic                  in_eop,
    output logic                  in_ready,
    input  logic [2:0]            filter_selection,
    input  logic [PITCH_W-1:0]    pitch_output,
    output logic [3*OUT_BITS-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_sop,
    output logic                  out_eop,
    input  logic                  out_ready,
    output logic [2:0]            active_mode
);
    localparam int PCW = $clog2(PITCH_MAX + 1);
    localparam int GW  = OUT_BITS + 8;
    localparam int PKW = OUT_BITS + 9 + PCW;
    localparam logic [OUT_BITS-1:0] MAX = '1;
    localparam logic [PITCH_W-1:0] P_MIN = PITCH_W'(PITCH_MIN);
    localparam logic [PITCH_W-1:0] P_MAX = PITCH_W'(PITCH_MAX);

    function automatic logic [OUT_BITS-1:0] expand(input logic [IN_BITS-1:0] c);
        return OUT_BITS'({c, c}) << (OUT_BITS - 2*IN_BITS);
    endfunction

    logic                advance, accept;
    logic [2:0]          mode_reg;
    logic [PCW-1:0]      pcap_reg, pcap_new;
    logic                s1_valid, s1_sop, s1_eop;
    logic [2:0]          s1_mode;
    logic [PCW-1:0]      s1_pcap;
    logic [OUT_BITS-1:0] s1_er, s1_eg, s1_eb;
    logic                s2_valid, s2_sop, s2_eop;
    logic [2:0]          s2_mode;
    logic [OUT_BITS-1:0] s2_er, s2_eg, s2_eb, s2_gray;
    logic [PKW-1:0]      s2_pk;
    logic [GW-1:0]       gsum;
    logic [PKW-1:0]      pk, kfull;
    logic [OUT_BITS-1:0] k;
    logic [3*OUT_BITS-1:0] out_next;

    assign advance     = !out_valid || out_ready;
    assign accept      = in_valid && advance;
    assign in_ready    = advance;
    assign active_mode = mode_reg;
    // Clamp is done at the full input width so large pitches saturate instead of wrapping.
    assign pcap_new = pitch_output < P_MIN ? PCW'(PITCH_MIN) :
                      pitch_output > P_MAX ? PCW'(PITCH_MAX) : pitch_output[PCW-1:0];

    always_comb begin
        gsum     = GW'(s1_er) * GW'(77) + GW'(s1_eg) * GW'(150) + GW'(s1_eb) * GW'(29);
        pk       = (PKW'(s1_er) * PKW'(120) + PKW'(s1_eg) * PKW'(60) + PKW'(s1_eb) * PKW'(50)) * PKW'(s1_pcap);
        kfull    = s2_pk >> 14;
        k        = |kfull[PKW-1:OUT_BITS] ? MAX : kfull[OUT_BITS-1:0];
        out_next = (s2_mode == 3'd0 || s2_mode == 3'd2) ? {3{s2_gray}} :
                   s2_mode == 3'd1 ? {k, k >> 2, k >> 1} :
                   s2_mode == 3'd4 ? {MAX - s2_er, MAX - s2_eg, MAX - s2_eb} :
                   s2_mode == 3'd6 ? {3{int'(s2_gray) >= THRESH ? MAX : OUT_BITS'(0)}} :
                   {s2_er, s2_eg, s2_eb};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_reg  <= '0;
            pcap_reg  <= PCW'(PITCH_MIN);
            s1_valid  <= 1'b0;
            s1_sop    <= 1'b0;
            s1_eop    <= 1'b0;
            s1_mode   <= '0;
            s1_pcap   <= '0;
            s1_er     <= '0;
            s1_eg     <= '0;
            s1_eb     <= '0;
            s2_valid  <= 1'b0;
            s2_sop    <= 1'b0;
            s2_eop    <= 1'b0;
            s2_mode   <= '0;
            s2_er     <= '0;
            s2_eg     <= '0;
            s2_eb     <= '0;
            s2_gray   <= '0;
            s2_pk     <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
        end else begin
            if (accept && in_sop) begin
                mode_reg <= filter_selection;
                pcap_reg <= pcap_new;
            end
            if (advance) begin
                s1_valid  <= in_valid;
                s1_sop    <= in_valid && in_sop;
                s1_eop    <= in_valid && in_eop;
                s1_mode   <= in_sop ? filter_selection : mode_reg;
                s1_pcap   <= in_sop ? pcap_new : pcap_reg;
                s1_er     <= expand(in_data[3*IN_BITS-1 -: IN_BITS]);
                s1_eg     <= expand(in_data[2*IN_BITS-1 -: IN_BITS]);
                s1_eb     <= expand(in_data[IN_BITS-1:0]);
                s2_valid  <= s1_valid;
                s2_sop    <= s1_sop;
                s2_eop    <= s1_eop;
                s2_mode   <= s1_mode;
                s2_er     <= s1_er;
                s2_eg     <= s1_eg;
                s2_eb     <= s1_eb;
                s2_gray   <= OUT_BITS'(gsum >> 8);
                s2_pk     <= pk;
                out_valid <= s2_valid;
                out_sop   <= s2_sop;
                out_eop   <= s2_eop;
                out_data  <= out_next;
            end
        end
    end
endmodule
